// File: rtl/uart_frame_loader_if.sv
// uart_frame_loader_if
// Bundles the UART byte strobe, the sample-RAM write port and the FFT
// handshake used by uart_frame_loader.
//   i_rx_flag   : uart_rx byte strobe, active-low
//   i_rx_byte   : received byte, valid while i_rx_flag is low
//   o_wr_en     : sample RAM write enable (one-cycle pulse)
//   o_wr_addr   : sample RAM write address (ADDR_W bits)
//   o_wr_data   : sample RAM write data {high byte, low byte}
//   o_fft_start : one-cycle pulse when a frame is complete
//   i_fft_done  : one-cycle pulse from the FFT core
//   o_busy      : high while waiting for the FFT
//   o_overrun   : sticky, a byte arrived while busy
//   o_frame_err : one-cycle pulse when a partial frame is discarded
// Modport master is the loader side, slave is the environment side.
interface uart_frame_loader_if #(
  parameter int ADDR_W = 8
);
  logic              i_rx_flag;
  logic [7:0]        i_rx_byte;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [15:0]       o_wr_data;
  logic              o_fft_start;
  logic              i_fft_done;
  logic              o_busy;
  logic              o_overrun;
  logic              o_frame_err;

  modport master (
    input  i_rx_flag, i_rx_byte, i_fft_done,
    output o_wr_en, o_wr_addr, o_wr_data, o_fft_start, o_busy, o_overrun, o_frame_err
  );

  modport slave (
    output i_rx_flag, i_rx_byte, i_fft_done,
    input  o_wr_en, o_wr_addr, o_wr_data, o_fft_start, o_busy, o_overrun, o_frame_err
  );
endinterface

// File: rtl/uart_frame_loader.sv
// uart_frame_loader
// Collects UART bytes, pairs them little-endian into 16-bit samples and
// writes them to consecutive sample RAM addresses. After N_SAMPLES samples
// it pulses the FFT start and ignores input (flagging overrun) until the
// FFT reports done. An inter-byte timeout discards a partial frame.
// Ports:
//   i_clk : system clock
//   i_rst : synchronous, active-high reset
//   bus   : uart_frame_loader_if.master (byte strobe, RAM write, FFT handshake)
// Optional build macro FRAME_SYNC_EN: adds a sync state that waits for a
// 8'hA5 header byte after reset, after FFT done and after a timeout.
module uart_frame_loader #(
  parameter int N_SAMPLES     = 256,
  parameter int ADDR_W        = 8,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  uart_frame_loader_if.master  bus
);

  localparam bit TMO_EN = (TIMEOUT_TICKS > 0);
  localparam int TW     = TMO_EN ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [TW-1:0]     TMO_MAX   = TW'(TIMEOUT_TICKS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_LO, S_HI, S_START, S_WAIT
`ifdef FRAME_SYNC_EN
    , S_SYNC
`endif
  } state_t;

`ifdef FRAME_SYNC_EN
  localparam state_t RESTART = S_SYNC;
`else
  localparam state_t RESTART = S_LO;
`endif

  state_t            state_q, state_d;
  logic              flag_q, flag_d;
  logic [7:0]        lo_q, lo_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_data_q, wr_data_d;
  logic              fft_start_q, fft_start_d;
  logic              overrun_q, overrun_d;
  logic              frame_err_q, frame_err_d;
  logic              accept;
  logic              counting;

  // A byte is taken on the high-to-low transition of the strobe, so a
  // strobe held low for several cycles is only seen once.
  assign accept = flag_q & ~bus.i_rx_flag;

  always_comb begin
    state_d     = state_q;
    flag_d      = bus.i_rx_flag;
    lo_d        = lo_q;
    count_d     = count_q;
    tmo_d       = tmo_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    fft_start_d = 1'b0;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    counting    = 1'b0;

    unique case (state_q)
      S_LO: begin
        if (accept) begin
          lo_d    = bus.i_rx_byte;
          tmo_d   = '0;
          state_d = S_HI;
        end else begin
          // Idle before the first sample of a frame never times out.
          counting = (count_q != '0);
        end
      end
      S_HI: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q;
          wr_data_d = {bus.i_rx_byte, lo_q};
          count_d   = count_q + 1'b1;
          tmo_d     = '0;
          state_d   = (count_q == LAST_ADDR) ? S_START : S_LO;
        end else begin
          counting = 1'b1;
        end
      end
      S_START: begin
        fft_start_d = 1'b1;
        count_d     = '0;
        tmo_d       = '0;
        state_d     = S_WAIT;
        if (accept) overrun_d = 1'b1;
      end
      S_WAIT: begin
        // A byte coinciding with done is still dropped.
        if (accept) overrun_d = 1'b1;
        if (bus.i_fft_done) state_d = RESTART;
        tmo_d = '0;
      end
`ifdef FRAME_SYNC_EN
      S_SYNC: begin
        tmo_d = '0;
        if (accept && (bus.i_rx_byte == 8'hA5)) begin
          count_d = '0;
          state_d = S_LO;
        end
      end
`endif
      default: state_d = RESTART;
    endcase

    // Timeout discards the latched low byte and the partial frame.
    if (TMO_EN && counting) begin
      if (tmo_q == TMO_MAX) begin
        state_d     = RESTART;
        count_d     = '0;
        tmo_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= RESTART;
      flag_q      <= 1'b1;
      lo_q        <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      fft_start_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flag_q      <= flag_d;
      lo_q        <= lo_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      fft_start_q <= fft_start_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.o_wr_en     = wr_en_q;
  assign bus.o_wr_addr   = wr_addr_q;
  assign bus.o_wr_data   = wr_data_q;
  assign bus.o_fft_start = fft_start_q;
  assign bus.o_busy      = (state_q == S_WAIT);
  assign bus.o_overrun   = overrun_q;
  assign bus.o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb_uart_frame_loader
// Directed self-checking bench for uart_frame_loader (default parameters).
// Each scenario task drives bytes and compares the outputs it observes
// against hand-computed values.
module tb_uart_frame_loader;

  localparam int N_SAMPLES     = 256;
  localparam int ADDR_W        = 8;
  localparam int TIMEOUT_TICKS = 4096;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   start_count;
  int   wr_count;

  uart_frame_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_frame_loader #(
    .N_SAMPLES    (N_SAMPLES),
    .ADDR_W       (ADDR_W),
    .TIMEOUT_TICKS(TIMEOUT_TICKS)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running tallies of start pulses and RAM writes seen on the bus.
  always @(negedge clk) begin
    if (bus.o_fft_start === 1'b1) start_count++;
    if (bus.o_wr_en === 1'b1) wr_count++;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drops the strobe at a falling clock edge, captures the write port one
  // cycle later, holds low for 'hold' cycles, raises it, and captures the
  // start pulse one cycle after that.
  task automatic send_byte(input logic [7:0] b, input int hold,
                           output logic wr, output logic [ADDR_W-1:0] addr,
                           output logic [15:0] data, output logic start);
    @(negedge clk);
    bus.i_rx_flag = 1'b0;
    bus.i_rx_byte = b;
    @(negedge clk);
    wr   = bus.o_wr_en;
    addr = bus.o_wr_addr;
    data = bus.o_wr_data;
    repeat (hold - 1) @(negedge clk);
    bus.i_rx_flag = 1'b1;
    @(negedge clk);
    start = bus.o_fft_start;
  endtask

  // Sends the frame header when the sync feature is built in.
  task automatic sync_header();
`ifdef FRAME_SYNC_EN
    logic wr, st;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    send_byte(8'hA5, 1, wr, a, d, st);
    checks++;
    if (wr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL header_no_write: wr_en=%b expected 0", wr);
    end
`endif
  endtask

  task automatic test_reset();
    do_reset();
    sync_header();
    checks += 7;
    if (bus.o_wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b expected 0", bus.o_wr_en); end
    if (bus.o_wr_addr !== '0) begin errors++; $display("[TB] FAIL reset_wr_addr: got %h expected 0", bus.o_wr_addr); end
    if (bus.o_wr_data !== '0) begin errors++; $display("[TB] FAIL reset_wr_data: got %h expected 0", bus.o_wr_data); end
    if (bus.o_fft_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_fft_start: got %b expected 0", bus.o_fft_start); end
    if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.o_busy); end
    if (bus.o_overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b expected 0", bus.o_overrun); end
    if (bus.o_frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", bus.o_frame_err); end
  endtask

  task automatic test_first_pair();
    logic wr, st;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    do_reset();
    sync_header();
    send_byte(8'h34, 1, wr, a, d, st);
    checks++;
    if (wr !== 1'b0) begin errors++; $display("[TB] FAIL pair_lo_no_write: wr_en=%b expected 0", wr); end
    send_byte(8'h12, 1, wr, a, d, st);
    checks += 3;
    if (wr !== 1'b1) begin errors++; $display("[TB] FAIL pair_wr_en: got %b expected 1", wr); end
    if (a !== 8'h00) begin errors++; $display("[TB] FAIL pair_addr: got %h expected 00", a); end
    if (d !== 16'h1234) begin errors++; $display("[TB] FAIL pair_data: got %h expected 1234", d); end
  endtask

  task automatic test_full_frame();
    logic wr, st;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    do_reset();
    sync_header();
    for (int k = 0; k < N_SAMPLES; k++) begin
      send_byte(8'(k), 1, wr, a, d, st);
      send_byte(8'h00, 1, wr, a, d, st);
      checks += 3;
      if (wr !== 1'b1 || a !== ADDR_W'(k)) begin
        errors++;
        $display("[TB] FAIL frame_addr[%0d]: wr_en=%b addr=%h expected wr_en=1 addr=%h", k, wr, a, ADDR_W'(k));
      end
      if (d !== 16'(k)) begin
        errors++;
        $display("[TB] FAIL frame_data[%0d]: got %h expected %h", k, d, 16'(k));
      end
      if (st !== (k == N_SAMPLES - 1)) begin
        errors++;
        $display("[TB] FAIL frame_start[%0d]: got %b expected %b", k, st, (k == N_SAMPLES - 1));
      end
    end
    checks++;
    if (bus.o_busy !== 1'b1) begin errors++; $display("[TB] FAIL frame_busy: got %b expected 1", bus.o_busy); end
  endtask

  task automatic test_overrun();
    logic wr, st;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    send_byte(8'h55, 1, wr, a, d, st);
    repeat (3) @(negedge clk);
    checks += 3;
    if (wr !== 1'b0) begin errors++; $display("[TB] FAIL overrun_no_write: wr_en=%b expected 0", wr); end
    if (bus.o_overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_set: got %b expected 1", bus.o_overrun); end
    if (bus.o_busy !== 1'b1) begin errors++; $display("[TB] FAIL overrun_busy: got %b expected 1", bus.o_busy); end
    bus.i_fft_done = 1'b1;
    @(negedge clk);
    bus.i_fft_done = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b0) begin errors++; $display("[TB] FAIL done_busy: got %b expected 0", bus.o_busy); end
    sync_header();
    send_byte(8'h01, 1, wr, a, d, st);
    send_byte(8'h00, 1, wr, a, d, st);
    checks += 3;
    if (wr !== 1'b1 || a !== 8'h00) begin errors++; $display("[TB] FAIL after_done_addr: wr_en=%b addr=%h expected wr_en=1 addr=00", wr, a); end
    if (d !== 16'h0001) begin errors++; $display("[TB] FAIL after_done_data: got %h expected 0001", d); end
    if (bus.o_overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_sticky: got %b expected 1", bus.o_overrun); end
  endtask

  task automatic test_timeout();
    logic wr, st, seen, wrote;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    int at;
    do_reset();
    sync_header();
    send_byte(8'h34, 1, wr, a, d, st);
    seen  = 1'b0;
    wrote = wr;
    at    = -1;
    for (int c = 0; c < TIMEOUT_TICKS + 20 && !seen; c++) begin
      @(negedge clk);
      if (bus.o_wr_en === 1'b1) wrote = 1'b1;
      if (bus.o_frame_err === 1'b1) begin seen = 1'b1; at = c; end
    end
    checks += 3;
    if (seen !== 1'b1) begin errors++; $display("[TB] FAIL timeout_frame_err: seen=%b expected 1", seen); end
    if (at < TIMEOUT_TICKS - 4 || at > TIMEOUT_TICKS + 4) begin
      errors++;
      $display("[TB] FAIL timeout_delay: got %0d cycles expected about %0d", at, TIMEOUT_TICKS);
    end
    if (wrote !== 1'b0) begin errors++; $display("[TB] FAIL timeout_no_write: wrote=%b expected 0", wrote); end
    sync_header();
    send_byte(8'hCD, 1, wr, a, d, st);
    send_byte(8'hAB, 1, wr, a, d, st);
    checks += 2;
    if (wr !== 1'b1 || a !== 8'h00) begin errors++; $display("[TB] FAIL timeout_next_addr: wr_en=%b addr=%h expected wr_en=1 addr=00", wr, a); end
    if (d !== 16'hABCD) begin errors++; $display("[TB] FAIL timeout_next_data: got %h expected abcd", d); end
  endtask

  task automatic test_hold_and_done();
    logic wr, st;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    int w0;
    do_reset();
    sync_header();
    w0 = wr_count;
    send_byte(8'h22, 3, wr, a, d, st);
    bus.i_fft_done = 1'b1;
    @(negedge clk);
    bus.i_fft_done = 1'b0;
    send_byte(8'h11, 1, wr, a, d, st);
    checks += 3;
    if (wr !== 1'b1 || a !== 8'h00) begin errors++; $display("[TB] FAIL hold_addr: wr_en=%b addr=%h expected wr_en=1 addr=00", wr, a); end
    if (d !== 16'h1122) begin errors++; $display("[TB] FAIL hold_data: got %h expected 1122", d); end
    if (wr_count - w0 !== 1) begin errors++; $display("[TB] FAIL hold_write_count: got %0d expected 1", wr_count - w0); end
  endtask

  task automatic test_reset_midframe();
    logic wr, st;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    do_reset();
    sync_header();
    for (int k = 0; k < 3; k++) begin
      send_byte(8'h40 + 8'(k), 1, wr, a, d, st);
      send_byte(8'h00, 1, wr, a, d, st);
      checks++;
      if (a !== ADDR_W'(k)) begin errors++; $display("[TB] FAIL mid_addr[%0d]: got %h expected %h", k, a, ADDR_W'(k)); end
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sync_header();
    send_byte(8'h99, 1, wr, a, d, st);
    send_byte(8'h88, 1, wr, a, d, st);
    checks += 3;
    if (wr !== 1'b1 || a !== 8'h00) begin errors++; $display("[TB] FAIL mid_reset_addr: wr_en=%b addr=%h expected wr_en=1 addr=00", wr, a); end
    if (d !== 16'h8899) begin errors++; $display("[TB] FAIL mid_reset_data: got %h expected 8899", d); end
    if (bus.o_overrun !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_overrun: got %b expected 0", bus.o_overrun); end
  endtask

`ifdef FRAME_SYNC_EN
  task automatic test_frame_sync();
    logic wr, st;
    logic [ADDR_W-1:0] a;
    logic [15:0] d;
    do_reset();
    send_byte(8'h11, 1, wr, a, d, st);
    checks++;
    if (wr !== 1'b0) begin errors++; $display("[TB] FAIL sync_junk_no_write: wr_en=%b expected 0", wr); end
    send_byte(8'hA5, 1, wr, a, d, st);
    checks++;
    if (wr !== 1'b0) begin errors++; $display("[TB] FAIL sync_hdr_no_write: wr_en=%b expected 0", wr); end
    send_byte(8'h78, 1, wr, a, d, st);
    send_byte(8'h56, 1, wr, a, d, st);
    checks += 2;
    if (wr !== 1'b1 || a !== 8'h00) begin errors++; $display("[TB] FAIL sync_addr: wr_en=%b addr=%h expected wr_en=1 addr=00", wr, a); end
    if (d !== 16'h5678) begin errors++; $display("[TB] FAIL sync_data: got %h expected 5678", d); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    start_count = 0;
    wr_count = 0;
    rst = 1'b1;
    bus.i_rx_flag  = 1'b1;
    bus.i_rx_byte  = 8'h00;
    bus.i_fft_done = 1'b0;
    test_reset();
    test_first_pair();
    test_full_frame();
    test_overrun();
    test_timeout();
    test_hold_and_done();
    test_reset_midframe();
`ifdef FRAME_SYNC_EN
    test_frame_sync();
`endif
    checks++;
    if (start_count !== 1) begin errors++; $display("[TB] FAIL start_pulse_total: got %0d expected 1", start_count); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
